saturn_bus_cmd_sequencer: RTL and testbench

//  Arbitrates two requesters (control unit, debugger) that push bus-program bursts.
//  A burst is one command word ({1'b1,cmd}) followed by zero or more nibble words ({1'b0,nibble}).

---
 rtl/saturn_bus_cmd_sequencer_if.sv | 29 ++
 rtl/saturn_bus_cmd_sequencer.sv | 150 +++++++++++++++
 tb/tb_saturn_bus_cmd_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/saturn_bus_cmd_sequencer_if.sv
// Request/bus-issue bundle for the Saturn bus command sequencer.
// The master side pushes bursts and acks issued words; the slave side is the sequencer.
interface saturn_bus_cmd_sequencer_if #(
  parameter int unsigned DEPTH_LOG2 = 5
);
  logic                  clk_en;
  logic [3:0]            phases;
  logic [1:0]            req_valid;
  logic [9:0]            req_data;
  logic [1:0]            req_last;
  logic [1:0]            req_ready;
  logic [1:0]            grant;
  logic                  bus_valid;
  logic [4:0]            bus_data;
  logic                  bus_ack;
  logic [DEPTH_LOG2:0]   level;
  logic                  busy;
  logic                  error;

  modport master (
    output clk_en, phases, req_valid, req_data, req_last, bus_ack,
    input  req_ready, grant, bus_valid, bus_data, level, busy, error
  );

  modport slave (
    input  clk_en, phases, req_valid, req_data, req_last, bus_ack,
    output req_ready, grant, bus_valid, bus_data, level, busy, error
  );
endinterface

// File: rtl/saturn_bus_cmd_sequencer.sv
// Two-requester burst arbiter feeding a circular word queue that drains to the bus
// controller one word per phase-0 ack.
module saturn_bus_cmd_sequencer #(
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  saturn_bus_cmd_sequencer_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned WW    = 5;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_nxt;
  logic [WW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [LW-1:0]         level, level_nxt;
  logic [1:0]            grant, grant_nxt;
  logic                  rr_ptr, rr_nxt;
  logic                  error, error_nxt;
  logic                  bus_valid;
  logic [WW-1:0]         bus_data, bus_data_nxt;
  logic                  busy;

  logic [WW-1:0]         word [2];
  logic [1:0]            win;
  logic                  win_idx;
  logic                  sel;
  logic                  not_full;
  logic                  push;
  logic                  pop;
  logic [WW-1:0]         push_word;
  logic                  unused_phases;

  assign word[0]       = bus.req_data[4:0];
  assign word[1]       = bus.req_data[9:5];
  assign not_full      = (level != LW'(DEPTH));
  assign sel           = grant[1];
  assign unused_phases = ^bus.phases[3:1];

  // Idle arbitration: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    win     = 2'b00;
    win_idx = 1'b0;
    if (state == IDLE && bus.clk_en) begin
      case (bus.req_valid)
        2'b01:   begin win = 2'b01; win_idx = 1'b0; end
        2'b10:   begin win = 2'b10; win_idx = 1'b1; end
        2'b11:   begin win_idx = ~rr_ptr; win = rr_ptr ? 2'b01 : 2'b10; end
        default: begin win = 2'b00; win_idx = 1'b0; end
      endcase
    end
  end

  assign bus.req_ready = (grant | win) & {2{not_full}};

  // Next-state: burst ownership, push selection and sticky protocol error.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    error_nxt = error;
    push      = 1'b0;
    push_word = word[0];
    case (state)
      IDLE: begin
        if ((win != 2'b00) && not_full) begin
          rr_nxt = win_idx;
          if (word[win_idx][4]) begin
            push      = 1'b1;
            push_word = word[win_idx];
            if (!bus.req_last[win_idx]) begin
              state_nxt = BURST;
              grant_nxt = win;
            end
          end else begin
            error_nxt = 1'b1;
          end
        end
      end
      BURST: begin
        if (bus.clk_en && bus.req_valid[sel] && not_full) begin
          push      = 1'b1;
          push_word = word[sel];
          if (bus.req_last[sel]) begin
            state_nxt = IDLE;
            grant_nxt = 2'b00;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  assign pop        = bus.clk_en & bus.phases[0] & bus_valid & bus.bus_ack;
  assign wr_ptr_nxt = wr_ptr + DEPTH_LOG2'(push);
  assign rd_ptr_nxt = rd_ptr + DEPTH_LOG2'(pop);
  assign level_nxt  = level + LW'(push) - LW'(pop);

  // Head after this cycle; a word written into an otherwise empty queue bypasses the array.
  always_comb begin
    bus_data_nxt = '0;
    if (level_nxt != '0) begin
      if (push && (wr_ptr == rd_ptr_nxt)) bus_data_nxt = push_word;
      else                                bus_data_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      grant     <= 2'b00;
      rr_ptr    <= 1'b0;
      error     <= 1'b0;
      bus_valid <= 1'b0;
      bus_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      level     <= level_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_nxt;
      error     <= error_nxt;
      bus_valid <= (level_nxt != '0);
      bus_data  <= bus_data_nxt;
      busy      <= (grant_nxt != 2'b00) || (level_nxt != '0);
    end
  end

  assign bus.grant     = grant;
  assign bus.bus_valid = bus_valid;
  assign bus.bus_data  = bus_data;
  assign bus.level     = level;
  assign bus.busy      = busy;
  assign bus.error     = error;
endmodule

// File: tb/tb_saturn_bus_cmd_sequencer.sv
// Directed bench for saturn_bus_cmd_sequencer: a vector table for the basic flows plus
// hand-written sequences for full queue, wrap, same-cycle push/pop and mid-burst reset.
module tb_saturn_bus_cmd_sequencer;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  saturn_bus_cmd_sequencer_if #(.DEPTH_LOG2(5)) ifc ();

  saturn_bus_cmd_sequencer #(.DEPTH_LOG2(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [3:0] ph;
    logic [1:0] vld;
    logic [9:0] data;
    logic [1:0] last;
    logic       ack;
    logic [1:0] e_ready;
    logic [1:0] e_grant;
    logic       e_bvalid;
    logic [4:0] e_bdata;
    logic [5:0] e_level;
    logic       e_busy;
    logic       e_error;
  } vec_t;

  localparam int unsigned NV = 19;
  vec_t vt [NV];
  logic [4:0] sb [$];

  function automatic vec_t mk(logic rst, logic en, logic [3:0] ph, logic [1:0] vld,
                              logic [9:0] data, logic [1:0] last, logic ack,
                              logic [1:0] er, logic [1:0] eg, logic ebv, logic [4:0] ebd,
                              logic [5:0] elv, logic ebz, logic eerr);
    vec_t r;
    r.rst = rst; r.en = en; r.ph = ph; r.vld = vld; r.data = data; r.last = last;
    r.ack = ack; r.e_ready = er; r.e_grant = eg; r.e_bvalid = ebv; r.e_bdata = ebd;
    r.e_level = elv; r.e_busy = ebz; r.e_error = eerr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] vld, input logic [9:0] data,
                       input logic [1:0] last, input logic ack);
    ifc.clk_en    = 1'b1;
    ifc.phases    = 4'b0001;
    ifc.req_valid = vld;
    ifc.req_data  = data;
    ifc.req_last  = last;
    ifc.bus_ack   = ack;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(2'b00, 10'h000, 2'b00, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [4:0] wd(input int i);
    return (i == 0) ? 5'h10 : {1'b0, 4'(i)};
  endfunction

  initial begin
    n_chk  = 0;
    n_pass = 0;
    sb     = {};

    //   rst en ph    vld    data             last   ack  rdy    grant bv bdata  lvl busy err
    vt[0]  = mk(1, 1, 4'h1, 2'b00, 10'h000,         2'b00, 0, 2'b00, 2'b00, 0, 5'h00, 0, 0, 0);
    vt[1]  = mk(0, 1, 4'h1, 2'b01, {5'h00, 5'h1A},  2'b00, 1, 2'b01, 2'b01, 1, 5'h1A, 1, 1, 0);
    vt[2]  = mk(0, 1, 4'h1, 2'b01, {5'h00, 5'h03},  2'b00, 1, 2'b01, 2'b01, 1, 5'h03, 1, 1, 0);
    vt[3]  = mk(0, 1, 4'h1, 2'b01, {5'h00, 5'h05},  2'b01, 1, 2'b01, 2'b00, 1, 5'h05, 1, 1, 0);
    vt[4]  = mk(0, 1, 4'h1, 2'b00, 10'h000,         2'b00, 1, 2'b00, 2'b00, 0, 5'h00, 0, 0, 0);
    vt[5]  = mk(0, 1, 4'h1, 2'b01, {5'h00, 5'h04},  2'b00, 0, 2'b01, 2'b00, 0, 5'h00, 0, 0, 1);
    vt[6]  = mk(0, 1, 4'h1, 2'b01, {5'h00, 5'h10},  2'b01, 0, 2'b01, 2'b00, 1, 5'h10, 1, 1, 1);
    vt[7]  = mk(0, 1, 4'h2, 2'b00, 10'h000,         2'b00, 1, 2'b00, 2'b00, 1, 5'h10, 1, 1, 1);
    vt[8]  = mk(0, 0, 4'h1, 2'b00, 10'h000,         2'b00, 1, 2'b00, 2'b00, 1, 5'h10, 1, 1, 1);
    vt[9]  = mk(0, 1, 4'h1, 2'b00, 10'h000,         2'b00, 1, 2'b00, 2'b00, 0, 5'h00, 0, 0, 1);
    vt[10] = mk(0, 0, 4'h1, 2'b01, {5'h00, 5'h1F},  2'b00, 0, 2'b00, 2'b00, 0, 5'h00, 0, 0, 1);
    vt[11] = mk(1, 1, 4'h1, 2'b00, 10'h000,         2'b00, 0, 2'b00, 2'b00, 0, 5'h00, 0, 0, 0);
    vt[12] = mk(0, 1, 4'h1, 2'b11, {5'h11, 5'h12},  2'b00, 0, 2'b10, 2'b10, 1, 5'h11, 1, 1, 0);
    vt[13] = mk(0, 1, 4'h1, 2'b11, {5'h02, 5'h12},  2'b10, 0, 2'b10, 2'b00, 1, 5'h11, 2, 1, 0);
    vt[14] = mk(0, 1, 4'h1, 2'b11, {5'h13, 5'h12},  2'b11, 0, 2'b01, 2'b00, 1, 5'h11, 3, 1, 0);
    vt[15] = mk(0, 1, 4'h1, 2'b10, {5'h13, 5'h12},  2'b10, 1, 2'b10, 2'b00, 1, 5'h02, 3, 1, 0);
    vt[16] = mk(0, 1, 4'h1, 2'b00, 10'h000,         2'b00, 1, 2'b00, 2'b00, 1, 5'h12, 2, 1, 0);
    vt[17] = mk(0, 1, 4'h1, 2'b00, 10'h000,         2'b00, 1, 2'b00, 2'b00, 1, 5'h13, 1, 1, 0);
    vt[18] = mk(0, 1, 4'h1, 2'b00, 10'h000,         2'b00, 1, 2'b00, 2'b00, 0, 5'h00, 0, 0, 0);

    do_reset();

    for (int i = 0; i < int'(NV); i++) begin
      reset         = vt[i].rst;
      ifc.clk_en    = vt[i].en;
      ifc.phases    = vt[i].ph;
      ifc.req_valid = vt[i].vld;
      ifc.req_data  = vt[i].data;
      ifc.req_last  = vt[i].last;
      ifc.bus_ack   = vt[i].ack;
      #2;
      chk($sformatf("v%0d_ready", i), 32'(ifc.req_ready), 32'(vt[i].e_ready));
      tick();
      chk($sformatf("v%0d_grant", i),  32'(ifc.grant),     32'(vt[i].e_grant));
      chk($sformatf("v%0d_bvalid", i), 32'(ifc.bus_valid), 32'(vt[i].e_bvalid));
      chk($sformatf("v%0d_bdata", i),  32'(ifc.bus_data),  32'(vt[i].e_bdata));
      chk($sformatf("v%0d_level", i),  32'(ifc.level),     32'(vt[i].e_level));
      chk($sformatf("v%0d_busy", i),   32'(ifc.busy),      32'(vt[i].e_busy));
      chk($sformatf("v%0d_error", i),  32'(ifc.error),     32'(vt[i].e_error));
    end
    reset = 1'b0;

    // Full queue: 32 accepted, the 33rd held until one ack frees a slot.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(2'b01, {5'h00, wd(i)}, 2'b00, 1'b0);
      chk("full_fill_ready", 32'(ifc.req_ready), 32'h1);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, {5'h00, wd(32)}, 2'b01, 1'b0);
      chk("full_hold_ready", 32'(ifc.req_ready), 32'h0);
      tick();
      chk("full_level", 32'(ifc.level), 32'd32);
    end
    drive(2'b01, {5'h00, wd(32)}, 2'b01, 1'b1);
    chk("full_ack_ready", 32'(ifc.req_ready), 32'h0);
    chk("full_ack_head", 32'(ifc.bus_data), 32'h10);
    tick();
    chk("full_after_ack_level", 32'(ifc.level), 32'd31);
    drive(2'b01, {5'h00, wd(32)}, 2'b01, 1'b0);
    chk("full_33rd_ready", 32'(ifc.req_ready), 32'h1);
    tick();
    chk("full_33rd_level", 32'(ifc.level), 32'd32);
    chk("full_33rd_grant", 32'(ifc.grant), 32'h0);
    for (int k = 1; k <= 32; k++) begin
      drive(2'b00, 10'h000, 2'b00, 1'b1);
      chk($sformatf("full_drain_%0d", k), 32'(ifc.bus_data), 32'(wd(k)));
      tick();
    end
    chk("full_drained_level", 32'(ifc.level), 32'd0);
    chk("full_drained_busy", 32'(ifc.busy), 32'd0);

    // Same-cycle push and pop at level 5, then 40 words streamed through the wrap.
    do_reset();
    for (int j = 0; j < 5; j++) begin
      logic [4:0] w;
      w = (j == 0) ? 5'h15 : {1'b0, 4'(j)};
      drive(2'b01, {5'h00, w}, 2'b00, 1'b0);
      sb.push_back(w);
      tick();
    end
    chk("pp_level_pre", 32'(ifc.level), 32'd5);
    drive(2'b01, {5'h00, 5'h0A}, 2'b00, 1'b1);
    chk("pp_head", 32'(ifc.bus_data), 32'(sb[0]));
    void'(sb.pop_front());
    sb.push_back(5'h0A);
    tick();
    chk("pp_level_same", 32'(ifc.level), 32'd5);
    for (int j = 0; j < 40; j++) begin
      logic [4:0] w;
      w = {1'b0, 4'(j + 3)};
      drive(2'b01, {5'h00, w}, {1'b0, j == 39}, 1'b1);
      chk($sformatf("wrap_ready_%0d", j), 32'(ifc.req_ready), 32'h1);
      chk($sformatf("wrap_head_%0d", j), 32'(ifc.bus_data), 32'(sb[0]));
      void'(sb.pop_front());
      sb.push_back(w);
      tick();
    end
    chk("wrap_level", 32'(ifc.level), 32'd5);
    for (int j = 0; j < 5; j++) begin
      drive(2'b00, 10'h000, 2'b00, 1'b1);
      chk($sformatf("wrap_drain_%0d", j), 32'(ifc.bus_data), 32'(sb[0]));
      void'(sb.pop_front());
      tick();
    end
    chk("wrap_empty_valid", 32'(ifc.bus_valid), 32'd0);

    // Reset mid-burst at level 7 with the error flag set.
    do_reset();
    drive(2'b01, {5'h00, 5'h04}, 2'b00, 1'b0);
    tick();
    for (int j = 0; j < 7; j++) begin
      drive(2'b01, {5'h00, (j == 0) ? 5'h17 : {1'b0, 4'(j)}}, 2'b00, 1'b0);
      tick();
    end
    chk("rst_pre_level", 32'(ifc.level), 32'd7);
    chk("rst_pre_grant", 32'(ifc.grant), 32'h1);
    chk("rst_pre_error", 32'(ifc.error), 32'h1);
    reset = 1'b1;
    drive(2'b01, {5'h00, 5'h07}, 2'b00, 1'b1);
    tick();
    reset = 1'b0;
    chk("rst_grant", 32'(ifc.grant), 32'h0);
    chk("rst_level", 32'(ifc.level), 32'h0);
    chk("rst_bvalid", 32'(ifc.bus_valid), 32'h0);
    chk("rst_bdata", 32'(ifc.bus_data), 32'h0);
    chk("rst_busy", 32'(ifc.busy), 32'h0);
    chk("rst_error", 32'(ifc.error), 32'h0);
    drive(2'b00, 10'h000, 2'b00, 1'b0);
    chk("rst_ready", 32'(ifc.req_ready), 32'h0);
    drive(2'b01, {5'h00, 5'h1C}, 2'b00, 1'b1);
    chk("post_rst_ready", 32'(ifc.req_ready), 32'h1);
    tick();
    chk("post_rst_head0", 32'(ifc.bus_data), 32'h1C);
    chk("post_rst_level0", 32'(ifc.level), 32'd1);
    drive(2'b01, {5'h00, 5'h09}, 2'b01, 1'b1);
    tick();
    chk("post_rst_head1", 32'(ifc.bus_data), 32'h09);
    drive(2'b00, 10'h000, 2'b00, 1'b1);
    tick();
    chk("post_rst_level_end", 32'(ifc.level), 32'd0);
    chk("post_rst_busy_end", 32'(ifc.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
